mux_4_to_1: RTL and testbench
=============================

// Module: mux_4_to_1
// PURPOSE
//  Registered 4:1 datapath selector. Picks one of three 32-bit scalar operands or one
//  192-bit vector operand and presents it on a 192-bit vector result bus.
//  Sits in the vector execute path and feeds the operand/writeback stage. Scalars are
//  zero-extended into the vector-width slot.
// PARAMETERS
//  SCALAR_W   32    width of scalar inputs A, B, C
//  LANES      6     number of 32-bit lanes in vector D / result E
//  VEC_W      LANES*SCALAR_W (192)   derived; must not be overridden independently
// PORTS
//  clk   input   1        rising-edge clock
//  rst   input   1        asynchronous, active-high reset
//  A     input   32       scalar operand 0
//  B     input   32       scalar operand 1
//  C     input   32       scalar operand 2
//  D     input   192      vector operand
//  sel   input   2        source select
//  E     output  192      registered selected result
// BEHAVIOUR
//  - Clocking: one clock (clk). Reset is asynchronous and active-high (rst).
//  - Reset: rst=1 forces E=192'h0 immediately, with no clock edge required.
//    E holds 0 while rst is asserted.
//  - Selection: combinational next value, registered on each rising clk edge:
//      sel=2'b00 -> {160'h0, A}   (A in bits [31:0], upper bits zero)
//      sel=2'b01 -> {160'h0, B}
//      sel=2'b10 -> {160'h0, C}
//      sel=2'b11 -> D             (all 192 bits passed unchanged)
//  - Latency: exactly 1 cycle. E after edge N reflects sel/A/B/C/D sampled at edge N.
//  - No enable and no handshake. E updates on every clock edge when rst=0.
//  - Bit ordering: lane k of D maps to lane k of E (bits [32k+31:32k]), with no swizzle.
//  - X/Z on sel: not required to be defined. X on sel must never be produced by design.
//  - Reset mid-stream: rst asserted between edges clears E asynchronously.
//    On the first edge after rst deasserts, E loads the selected value.
//  - No state beyond the E register. No overflow or arithmetic is involved.
// TESTING
//  Use A=32'h80000000, B=32'h80000001, C=32'h80000002, D={6{32'hBC7E0F03}}.
//  1. Assert rst with a nonzero E -> E==0 immediately (before any clk edge).
//     E stays 0 across edges while rst=1.
//  2. Deassert rst, sel=00, clock once -> E==192'h0...0_80000000 (upper 160 bits zero).
//  3. sel=01, clock -> E low word 32'h80000001, upper 160 bits zero.
//     sel=10, clock -> E low word 32'h80000002, upper 160 bits zero.
//  4. sel=11, clock -> E=={6{32'hBC7E0F03}}.
//     Verify E is unchanged until the edge (one-cycle latency).
//  5. Back-to-back: change sel every cycle 00,01,10,11 -> E follows one cycle later in the same order.
//  6. Pulse rst while sel=11 mid-cycle -> E drops to 0 asynchronously.
//     First edge after release -> E=={6{32'hBC7E0F03}}.

Source files
------------

// File: rtl/mux_4_to_1.sv
// Registered 4:1 operand selector for the vector execute path.
// Scalars are zero-extended into the vector-width result slot.
module mux_4_to_1 #(
    parameter int SCALAR_W = 32,
    parameter int LANES    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SCALAR_W-1:0]       A,
    input  logic [SCALAR_W-1:0]       B,
    input  logic [SCALAR_W-1:0]       C,
    input  logic [LANES*SCALAR_W-1:0] D,
    input  logic [1:0]                sel,
    output logic [LANES*SCALAR_W-1:0] E
);

    localparam int VEC_W = LANES * SCALAR_W;

    logic [VEC_W-1:0] e_d;
    logic [VEC_W-1:0] e_q;

    always_comb begin
        e_d = '0;
        unique case (sel)
            2'b00:   e_d[SCALAR_W-1:0] = A;
            2'b01:   e_d[SCALAR_W-1:0] = B;
            2'b10:   e_d[SCALAR_W-1:0] = C;
            default: e_d = D;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign E = e_q;

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed, table-driven bench for mux_4_to_1.
// Covers async reset, selection, latency and lane ordering.
module tb_mux_4_to_1;

    logic         clk;
    logic         rst;
    logic [31:0]  A;
    logic [31:0]  B;
    logic [31:0]  C;
    logic [191:0] D;
    logic [1:0]   sel;
    logic [191:0] E;

    int total;
    int bad;

    typedef struct {
        logic [1:0]   sel;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  c;
        logic [191:0] d;
        logic [191:0] exp;
    } vec_t;

    vec_t vt [8];

    localparam logic [31:0]  SA = 32'h80000000;
    localparam logic [31:0]  SB = 32'h80000001;
    localparam logic [31:0]  SC = 32'h80000002;
    localparam logic [191:0] SD = {6{32'hBC7E0F03}};
    localparam logic [191:0] LD = 192'h66666666_55555555_44444444_33333333_22222222_11111111;

    mux_4_to_1 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .sel (sel),
        .E   (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c,
                         input logic [191:0] d);
        @(negedge clk);
        sel = s;
        A   = a;
        B   = b;
        C   = c;
        D   = d;
    endtask

    logic [191:0] prev;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        sel   = 2'b11;
        A     = SA;
        B     = SB;
        C     = SC;
        D     = SD;

        vt[0] = '{2'b01, SA, SB, SC, SD, {160'h0, 32'h80000001}};
        vt[1] = '{2'b10, SA, SB, SC, SD, {160'h0, 32'h80000002}};
        vt[2] = '{2'b11, SA, SB, SC, SD, {6{32'hBC7E0F03}}};
        vt[3] = '{2'b11, SA, SB, SC, LD, LD};
        vt[4] = '{2'b00, 32'hFFFFFFFF, SB, SC, {192{1'b1}},
                  {160'h0, 32'hFFFFFFFF}};
        vt[5] = '{2'b01, 32'hFFFFFFFF, 32'h00000001, SC, {192{1'b1}},
                  {160'h0, 32'h00000001}};
        vt[6] = '{2'b10, SA, SB, 32'hDEADBEEF, LD,
                  {160'h0, 32'hDEADBEEF}};
        vt[7] = '{2'b11, 32'hFFFFFFFF, SB, SC, 192'h0, 192'h0};

        // Load a nonzero value before exercising reset
        tick();
        tick();
        check("preload", 0, E, SD);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst", 0, E, 192'h0);
        tick();
        check("rst_hold", 0, E, 192'h0);
        tick();
        check("rst_hold", 1, E, 192'h0);

        @(negedge clk);
        rst = 1'b0;
        sel = 2'b00;
        tick();
        check("sel00", 0, E, {160'h0, 32'h80000000});
        check("sel00_upper", 0, {32'h0, E[191:32]}, 192'h0);
        prev = {160'h0, 32'h80000000};

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].sel, vt[i].a, vt[i].b, vt[i].c, vt[i].d);
            #1;
            check("latency", i, E, prev);
            tick();
            check("vec", i, E, vt[i].exp);
            prev = vt[i].exp;
        end

        drive(2'b00, SA, SB, SC, SD);
        tick();
        check("b2b", 0, E, {160'h0, SA});
        drive(2'b01, SA, SB, SC, SD);
        tick();
        check("b2b", 1, E, {160'h0, SB});
        drive(2'b10, SA, SB, SC, SD);
        tick();
        check("b2b", 2, E, {160'h0, SC});
        drive(2'b11, SA, SB, SC, SD);
        tick();
        check("b2b", 3, E, SD);

        drive(2'b11, SA, SB, SC, SD);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst", 0, E, 192'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_hold", 0, E, 192'h0);
        tick();
        check("post_rst", 0, E, SD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
